// File: rtl/ps2_scancode_rx.sv
// ----------------------------------------------------------------------------
// Module: ps2_scancode_rx
//
// Purpose:
//   Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd parity,
//   stop) and delivers each accepted byte as a held scancode plus a
//   one-cycle flag pulse. Framing and parity are checked, and a watchdog
//   drops a partial frame if ps2_clk stops toggling mid-frame.
//
// Parameters:
//   TIMEOUT_CYC : clk cycles without a ps2_clk falling edge (while a frame
//                 is in progress) before the partial frame is dropped.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   ps2_clk   in   raw PS/2 clock pin (asynchronous)
//   ps2_data  in   raw PS/2 data pin (asynchronous)
//   scancode  out  last accepted byte, held until the next accepted byte
//   flag      out  one-cycle pulse: scancode was updated this cycle
//   err       out  one-cycle pulse: parity error, stop-bit error or timeout
//
// Configuration:
//   PS2_BREAK_FILTER_EN : when defined, break prefixes (F0 plus the byte that
//                         follows it) and extended prefixes (E0) are swallowed
//                         so only make codes reach the downstream decoder.
//                         When undefined, every accepted byte pulses flag.
// ----------------------------------------------------------------------------
module ps2_scancode_rx #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       flag,
    output logic       err
);

    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state;
    logic            clk_s1;
    logic            clk_s2;
    logic            clk_prev;
    logic            data_s1;
    logic            data_s2;
    logic [7:0]      shift;
    logic [3:0]      bit_cnt;
    logic            parity_bit;
    logic [WD_W-1:0] wdog;
    logic            fall;
    logic            data_bit;
    logic            frame_ok;
`ifdef PS2_BREAK_FILTER_EN
    logic            break_pending;
`endif

    // Both pins are asynchronous to clk, so each passes through a two-stage
    // synchronizer. A third stage on the clock pin holds the previous synced
    // value for falling-edge detection. Everything resets to the idle-high
    // line level so releasing reset never fakes an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;
        end
    end

    // The keyboard changes data while ps2_clk is high, so the data pin is
    // only sampled on a detected falling edge. The stop bit must be 1 and
    // the nine data+parity bits must hold an odd number of ones.
    assign fall     = clk_prev & ~clk_s2;
    assign data_bit = data_s2;
    assign frame_ok = data_bit & (^{shift, parity_bit});

    // Frame receiver FSM with registered outputs. flag and err default low
    // every cycle so each one can only ever be a single-cycle pulse. The
    // watchdog check comes last so a timeout overrides the state update,
    // but it is gated by !fall so an edge arriving in the expiry cycle wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= 8'h00;
            bit_cnt    <= 4'd0;
            parity_bit <= 1'b0;
            wdog       <= '0;
            scancode   <= 8'h00;
            flag       <= 1'b0;
            err        <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            break_pending <= 1'b0;
`endif
        end else begin
            flag <= 1'b0;
            err  <= 1'b0;

            if (fall || state == IDLE) begin
                wdog <= '0;
            end else begin
                wdog <= wdog + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (fall && !data_bit) begin
                        shift   <= 8'h00;
                        bit_cnt <= 4'd0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (fall) begin
                        shift   <= {data_bit, shift[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (fall) begin
                        parity_bit <= data_bit;
                        state      <= STOP;
                    end
                end
                STOP: begin
                    if (fall) begin
                        state <= IDLE;
                        if (frame_ok) begin
`ifdef PS2_BREAK_FILTER_EN
                            if (shift == 8'hF0) begin
                                break_pending <= 1'b1;
                            end else if (shift == 8'hE0) begin
                                break_pending <= break_pending;
                            end else if (break_pending) begin
                                break_pending <= 1'b0;
                            end else begin
                                scancode <= shift;
                                flag     <= 1'b1;
                            end
`else
                            scancode <= shift;
                            flag     <= 1'b1;
`endif
                        end else begin
                            err <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                            break_pending <= 1'b0;
`endif
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (state != IDLE && !fall && wdog == WD_LAST) begin
                state   <= IDLE;
                shift   <= 8'h00;
                bit_cnt <= 4'd0;
                wdog    <= '0;
                err     <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                break_pending <= 1'b0;
`endif
            end
        end
    end

endmodule
